// File: rtl/gene_compact_writer_if.sv
// Deletion-stage gene stream in, child-genome memory write port and status out.
interface gene_compact_writer_if #(
    parameter int unsigned GENE_SZ = 64,
    parameter int unsigned ATTR_SZ = 8,
    parameter int unsigned ADDR_SZ = 8
);
    logic               setup;
    logic [ADDR_SZ-1:0] base_addr;
    logic               state;
    logic [GENE_SZ-1:0] gene_in;
    logic               in_valid;
    logic               stream_end;
    logic               mem_ready;
    logic               mem_wr_en;
    logic [ADDR_SZ-1:0] mem_wr_addr;
    logic [GENE_SZ-1:0] mem_wr_data;
    logic [ATTR_SZ-1:0] node_count;
    logic [ATTR_SZ-1:0] conn_count;
    logic [ADDR_SZ-1:0] conn_base_addr;
    logic               done;
    logic               overflow;

    // Upstream/stimulus side
    modport master (
        output setup, base_addr, state, gene_in, in_valid, stream_end, mem_ready,
        input  mem_wr_en, mem_wr_addr, mem_wr_data, node_count, conn_count,
               conn_base_addr, done, overflow
    );

    // Writer side
    modport slave (
        input  setup, base_addr, state, gene_in, in_valid, stream_end, mem_ready,
        output mem_wr_en, mem_wr_addr, mem_wr_data, node_count, conn_count,
               conn_base_addr, done, overflow
    );
endinterface

// File: rtl/gene_compact_writer.sv
// Squeezes bubbles out of the deletion-stage gene stream and writes the
// surviving genes contiguously into child-genome memory via a small FIFO.
module gene_compact_writer #(
    parameter int unsigned GENE_SZ    = 64,
    parameter int unsigned ATTR_SZ    = 8,
    parameter int unsigned ADDR_SZ    = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    gene_compact_writer_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ATTR_SZ-1:0] ATTR_MAX = '1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [GENE_SZ-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_SZ-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SZ-1:0] push_addr_q, push_addr_d;
    logic [ADDR_SZ-1:0] conn_base_q, conn_base_d;
    logic [ATTR_SZ-1:0] node_cnt_q, node_cnt_d, conn_cnt_q, conn_cnt_d;
    logic               conn_seen_q, conn_seen_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;
    logic               wr_en_q, wr_en_d;
    logic [GENE_SZ-1:0] wr_data_q, wr_data_d;
    logic               push, pop, full;

    // Next-state, FIFO bookkeeping, counters and the next write-port values
    always_comb begin
        fsm_d       = fsm_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        wr_addr_d   = wr_addr_q;
        push_addr_d = push_addr_q;
        conn_base_d = conn_base_q;
        node_cnt_d  = node_cnt_q;
        conn_cnt_d  = conn_cnt_q;
        conn_seen_d = conn_seen_q;
        overflow_d  = overflow_q;
        wr_data_d   = wr_data_q;
        full        = (cnt_q == FULL_CNT);
        pop         = wr_en_q & bus.mem_ready;
        push        = 1'b0;

        if (bus.setup) begin
            fsm_d       = STREAM;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            cnt_d       = '0;
            wr_addr_d   = bus.base_addr;
            push_addr_d = bus.base_addr;
            conn_base_d = bus.base_addr;
            node_cnt_d  = '0;
            conn_cnt_d  = '0;
            conn_seen_d = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            if (fsm_q == STREAM) begin
                if (bus.in_valid) begin
                    if (!full || pop) begin
                        push = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (bus.stream_end) begin
                    fsm_d = DRAIN;
                end
            end

            if (pop) begin
                rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                wr_addr_d = wr_addr_q + ADDR_SZ'(1);
            end

            if (push) begin
                wr_ptr_d    = wr_ptr_q + PTR_W'(1);
                push_addr_d = push_addr_q + ADDR_SZ'(1);
                if (bus.state) begin
                    if (conn_cnt_q != ATTR_MAX) begin
                        conn_cnt_d = conn_cnt_q + ATTR_SZ'(1);
                    end
                    if (!conn_seen_q) begin
                        conn_seen_d = 1'b1;
                        conn_base_d = push_addr_q;
                    end
                end else if (node_cnt_q != ATTR_MAX) begin
                    node_cnt_d = node_cnt_q + ATTR_SZ'(1);
                end
            end

            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

            // Pushes are closed in DRAIN, so push_addr_q already holds the total
            if (fsm_q == DRAIN && cnt_d == '0) begin
                fsm_d = DONE;
                if (!conn_seen_q) begin
                    conn_base_d = push_addr_q;
                end
            end

            // Head after this cycle: incoming gene if the FIFO ran dry, else stored entry
            if ((cnt_q - CNT_W'(pop)) == '0) begin
                if (push) begin
                    wr_data_d = bus.gene_in;
                end
            end else begin
                wr_data_d = fifo_mem[rd_ptr_d];
            end
        end

        wr_en_d = ((fsm_d == STREAM) || (fsm_d == DRAIN)) && (cnt_d != '0);
        done_d  = (fsm_d == DONE);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            wr_addr_q   <= '0;
            push_addr_q <= '0;
            conn_base_q <= '0;
            node_cnt_q  <= '0;
            conn_cnt_q  <= '0;
            conn_seen_q <= 1'b0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            wr_addr_q   <= wr_addr_d;
            push_addr_q <= push_addr_d;
            conn_base_q <= conn_base_d;
            node_cnt_q  <= node_cnt_d;
            conn_cnt_q  <= conn_cnt_d;
            conn_seen_q <= conn_seen_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // FIFO storage; contents beyond the pointers are don't-care so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.gene_in;
        end
    end

    assign bus.mem_wr_en      = wr_en_q;
    assign bus.mem_wr_addr    = wr_addr_q;
    assign bus.mem_wr_data    = wr_data_q;
    assign bus.node_count     = node_cnt_q;
    assign bus.conn_count     = conn_cnt_q;
    assign bus.conn_base_addr = conn_base_q;
    assign bus.done           = done_q;
    assign bus.overflow       = overflow_q;
endmodule
